spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter SIZE, default 8: bits per transfer; SHALL be >= 2.
REQ-002 Parameter DIV, default 2: Clk cycles per SClk half-period; SHALL be >= 1.
REQ-003 Clk  input  1  system clock; all state updates occur on the rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request one transfer; sampled only in IDLE.
REQ-006 Abort  input  1  terminate the transfer in progress.
REQ-007 Busy  output  1  high in every state except IDLE.
REQ-008 Done  output  1  one-cycle pulse marking transfer completion.
REQ-009 Load  output  1  parallel-load strobe to the companion shift register.
REQ-010 Shift  output  1  shift-enable strobe to the companion shift register.
REQ-011 SClk  output  1  SPI serial clock, mode 0 (idle low).
REQ-012 CS_n  output  1  SPI chip select, active low.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, LOW, HIGH and DONE.
REQ-014 IDLE->LOAD SHALL occur when Start=1; otherwise the FSM SHALL stay in IDLE.
REQ-015 LOAD SHALL last exactly one cycle, then go to LOW with phase count 0 and bit count 0.
REQ-016 LOW SHALL last DIV cycles, then go to HIGH.
REQ-017 HIGH SHALL last DIV cycles, then increment the bit count; if the count reaches SIZE the FSM SHALL go to DONE, otherwise to LOW.
REQ-018 DONE SHALL last one cycle, then go to IDLE.
REQ-019 All outputs SHALL be decoded from registered state only, with no combinational path from Start or Abort.
REQ-020 Load=1 iff state=LOAD.
REQ-021 Shift=1 iff state=HIGH and phase count=0, giving exactly SIZE Shift pulses per transfer.
REQ-022 SClk=1 iff state=HIGH.
REQ-023 CS_n=0 in LOAD, LOW and HIGH; CS_n=1 in IDLE and DONE.
REQ-024 Done=1 iff state=DONE.
REQ-025 Busy=1 iff state is not IDLE.
REQ-026 Latency: with Start=1 in cycle 0, Done SHALL be 1 in cycle 2+2*DIV*SIZE and Busy SHALL be 0 in the following cycle.
REQ-027 Start while Busy=1, including the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-028 Start in the cycle immediately after DONE SHALL begin a new transfer.
REQ-029 Abort=1 in LOAD, LOW or HIGH SHALL force IDLE on the next edge: no Done pulse, no further Shift, SClk=0, CS_n=1.
REQ-030 Abort SHALL take priority over every other transition; Abort in IDLE or DONE SHALL have no effect.
REQ-031 Start=1 and Abort=1 together in IDLE SHALL start a transfer.
REQ-032 The phase counter SHALL be $clog2(DIV) bits wide (minimum 1).
REQ-033 The bit counter SHALL be $clog2(SIZE+1) bits wide, SHALL never wrap, and SHALL clear on entry to LOAD.

Reset
REQ-034 While Rst=1 the state SHALL be IDLE and both counters SHALL be 0, regardless of Clk.
REQ-035 Reset output values SHALL be: Busy=0, Done=0, Load=0, Shift=0, SClk=0, CS_n=1.
REQ-036 Rst asserted mid-transfer SHALL take effect immediately and asynchronously, with no Done pulse.
REQ-037 After Rst deasserts, the first transfer SHALL require a fresh Start.

Structure
REQ-038 The state encodings and the SIZE/DIV defaults SHALL reside in a shared package spi_pkg.
REQ-039 spi_master_ctrl SHALL contain no sub-modules.
REQ-040 The spi_master top level SHALL instantiate spi_master_ctrl beside the shift register and connect it as follows:
- Load and Shift drive the shift register's load and enable inputs.
- MISO drives the shift register's serial input.
- The shift register's serial output drives MOSI.
- Rst is inverted to drive the shift register's active-low reset.

Verification
REQ-041 Nominal transfer, SIZE=8, DIV=2: Start pulse in cycle 0 -> Load in cycle 1; 8 Shift pulses at cycles 2+4k+2 (k=0..7); Done in cycle 34; CS_n low in cycles 1..33.
REQ-042 Back-to-back: Start held high continuously -> Start in cycle 34 is ignored; the second Load occurs in cycle 36; no Start is lost or duplicated.
REQ-043 Abort: Abort=1 in cycle 10 -> IDLE in cycle 11 with CS_n=1 and SClk=0; no Done; exactly 2 Shift pulses counted.
REQ-044 Mid-transfer reset: Rst pulsed asynchronously during HIGH -> SClk=0 and CS_n=1 immediately; Busy=0; no Done.
REQ-045 DIV=1, SIZE=2: Start in cycle 0 -> SClk pattern 0,1,0,1; Done in cycle 6.
REQ-046 Loopback with the shift register (MOSI tied to MISO), TxData=0xA5 -> data read back after Done equals 0xA5.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, defaults and helpers for the SPI master
package spi_pkg;

  localparam int SIZE_DEF = 8;
  localparam int DIV_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Counter width for a count of n values, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master: sequencer plus shift register datapath
module spi_master
  import spi_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int DIV  = DIV_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic            Abort,
  input  logic [SIZE-1:0] Tx_data,
  input  logic            MISO,
  output logic            MOSI,
  output logic            SClk,
  output logic            CS_n,
  output logic            Busy,
  output logic            Done,
  output logic [SIZE-1:0] Rx_data
);

  logic load, shift;
  logic rst_n;

  assign rst_n = ~Rst;

  spi_master_ctrl #(.SIZE(SIZE), .DIV(DIV)) u_ctrl (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .Abort (Abort),
    .Busy  (Busy),
    .Done  (Done),
    .Load  (load),
    .Shift (shift),
    .SClk  (SClk),
    .CS_n  (CS_n)
  );

  spi_shift_reg #(.SIZE(SIZE)) u_sr (
    .Clk      (Clk),
    .Rst_n    (rst_n),
    .Load     (load),
    .En       (shift),
    .Data_in  (Tx_data),
    .Sin      (MISO),
    .Sout     (MOSI),
    .Data_out (Rx_data)
  );

endmodule

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - MSB-first parallel-load shift register for SPI data
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Load,
  input  logic            En,
  input  logic [SIZE-1:0] Data_in,
  input  logic            Sin,
  output logic            Sout,
  output logic [SIZE-1:0] Data_out
);

  logic [SIZE-1:0] sr;

  // Load has priority over shifting; bits leave at the MSB and enter at the LSB
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sr <= '0;
    end else if (Load) begin
      sr <= Data_in;
    end else if (En) begin
      sr <= {sr[SIZE-2:0], Sin};
    end
  end

  assign Sout     = sr[SIZE-1];
  assign Data_out = sr;

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode 0 transfer sequencer driving a companion shift register
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int DIV  = DIV_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Start,
  input  logic Abort,
  output logic Busy,
  output logic Done,
  output logic Load,
  output logic Shift,
  output logic SClk,
  output logic CS_n
);

  localparam int PW = cnt_width(DIV);
  localparam int BW = $clog2(SIZE + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;

  // State and counter registers, cleared asynchronously
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= ST_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // Next-state and counter update; Abort overrides everything while a transfer is active
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_LOAD;
          phase_nxt = '0;
          bit_nxt   = '0;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_LOW;
        phase_nxt = '0;
        bit_nxt   = '0;
      end
      ST_LOW: begin
        if (phase == PH_LAST) begin
          state_nxt = ST_HIGH;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase == PH_LAST) begin
          phase_nxt = '0;
          bit_nxt   = bit_cnt + 1'b1;
          state_nxt = (bit_cnt == BIT_LAST) ? ST_DONE : ST_LOW;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = '0;
        bit_nxt   = '0;
      end
    endcase
    if (Abort && (state == ST_LOAD || state == ST_LOW || state == ST_HIGH)) begin
      state_nxt = ST_IDLE;
      phase_nxt = '0;
      bit_nxt   = '0;
    end
  end

  // Outputs depend on registered state only, so Start/Abort never reach them combinationally
  assign Busy  = (state != ST_IDLE);
  assign Done  = (state == ST_DONE);
  assign Load  = (state == ST_LOAD);
  assign Shift = (state == ST_HIGH) && (phase == '0);
  assign SClk  = (state == ST_HIGH);
  assign CS_n  = !(state == ST_LOAD || state == ST_LOW || state == ST_HIGH);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl and the loopback master
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  wire  busy, done, load, shift, sclk, cs_n;
  logic rst2, start2, abort2;
  wire  busy2, done2, load2, shift2, sclk2, cs_n2;
  logic start3, abort3;
  logic [7:0] tx;
  wire  [7:0] rx;
  wire  mosi, sclk3, cs_n3, busy3, done3;

  spi_master_ctrl #(.SIZE(8), .DIV(2)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Abort(abort),
    .Busy(busy), .Done(done), .Load(load), .Shift(shift), .SClk(sclk), .CS_n(cs_n)
  );

  spi_master_ctrl #(.SIZE(2), .DIV(1)) dut2 (
    .Clk(clk), .Rst(rst2), .Start(start2), .Abort(abort2),
    .Busy(busy2), .Done(done2), .Load(load2), .Shift(shift2), .SClk(sclk2), .CS_n(cs_n2)
  );

  spi_master #(.SIZE(8), .DIV(2)) u_lb (
    .Clk(clk), .Rst(rst2), .Start(start3), .Abort(abort3), .Tx_data(tx),
    .MISO(mosi), .MOSI(mosi), .SClk(sclk3), .CS_n(cs_n3),
    .Busy(busy3), .Done(done3), .Rx_data(rx)
  );

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] rx_q[$];
  string      kname[3] = '{"Load", "Shift", "Done"};
  int  cyc = 0;
  int  c0 = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  mon_sel = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] obs;
      obs = mon_sel ? {done2, shift2, load2} : {done, shift, load};
      for (int k = 0; k < 3; k++) begin
        if (obs[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_%s: pulse at cycle %0d, required none", kname[k], cyc - c0);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.kind !== k || e.at !== cyc - c0) begin
              errors++;
              $display("FAIL sb_event: got %s at cycle %0d, required %s at cycle %0d",
                       kname[k], cyc - c0, kname[e.kind], e.at);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic push_xfer8(input int base);
    push_ev(0, base + 1);
    for (int k = 0; k < 8; k++) push_ev(1, base + 4 + 4 * k);
    push_ev(2, base + 34);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, load, shift, sclk, cs_n} !== 6'b000001) begin
        errors++;
        $display("FAIL reset_outputs: got %b, required 000001", {busy, done, load, shift, sclk, cs_n});
      end
    end
    step();
    rst = 1'b0; rst2 = 1'b0; start = 1'b0;
    mon_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cs_n !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_idle: busy=%b cs_n=%b, required 0 1", busy, cs_n);
      end
    end
  endtask

  task automatic test_nominal();
    logic exp_cs, exp_busy, exp_sclk;
    step();
    c0 = cyc;
    start = 1'b1;
    push_xfer8(0);
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      exp_cs   = !(n >= 1 && n <= 33);
      exp_busy = (n >= 1 && n <= 34);
      exp_sclk = (n >= 2 && n <= 33 && ((n - 2) % 4) >= 2);
      checks++;
      if ({busy, cs_n, sclk} !== {exp_busy, exp_cs, exp_sclk}) begin
        errors++;
        $display("FAIL nominal_outputs: cycle %0d busy/cs_n/sclk=%b, required %b",
                 n, {busy, cs_n, sclk}, {exp_busy, exp_cs, exp_sclk});
      end
      step();
      if (n == 0) start = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL nominal_pending: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_busy;
    step();
    c0 = cyc;
    start = 1'b1;
    push_xfer8(0);
    push_xfer8(35);
    for (int n = 0; n <= 75; n++) begin
      @(negedge clk);
      exp_busy = (n >= 1 && n <= 34) || (n >= 36 && n <= 69);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b_busy: cycle %0d busy=%b, required %b", n, busy, exp_busy);
      end
      step();
      if (n == 69) start = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort();
    step();
    c0 = cyc;
    start = 1'b1;
    push_ev(0, 1); push_ev(1, 4); push_ev(1, 8);
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (n >= 11) begin
        checks++;
        if ({busy, cs_n, sclk} !== 3'b010) begin
          errors++;
          $display("FAIL abort_idle: cycle %0d busy/cs_n/sclk=%b, required 010", n, {busy, cs_n, sclk});
        end
      end
      step();
      if (n == 0) start = 1'b0;
      if (n == 9) abort = 1'b1;
      if (n == 10) abort = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_pending: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
    c0 = cyc;
    start = 1'b1;
    abort = 1'b1;
    push_ev(0, 1);
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL abort_start_priority: busy=%b, required 1", busy);
        end
      end
      if (n >= 2) begin
        checks++;
        if ({busy, cs_n} !== 2'b01) begin
          errors++;
          $display("FAIL abort_in_load: cycle %0d busy/cs_n=%b, required 01", n, {busy, cs_n});
        end
      end
      step();
      if (n == 0) start = 1'b0;
      if (n == 1) abort = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_load_pending: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    step();
    c0 = cyc;
    start = 1'b1;
    push_ev(0, 1); push_ev(1, 4);
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      step();
      if (n == 0) start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (sclk !== 1'b1) begin
      errors++;
      $display("FAIL midrst_high: sclk=%b, required 1", sclk);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sclk, cs_n} !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_async: busy/done/sclk/cs_n=%b, required 0001", {busy, done, sclk, cs_n});
    end
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_restart: busy=%b done=%b, required 0 0", busy, done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_pending: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_div1();
    logic exp_sclk;
    step();
    mon_sel = 1'b1;
    c0 = cyc;
    start2 = 1'b1;
    push_ev(0, 1); push_ev(1, 3); push_ev(1, 5); push_ev(2, 6);
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      if (n >= 2 && n <= 5) begin
        exp_sclk = (n == 3 || n == 5);
        checks++;
        if (sclk2 !== exp_sclk) begin
          errors++;
          $display("FAIL div1_sclk: cycle %0d sclk=%b, required %b", n, sclk2, exp_sclk);
        end
      end
      if (n == 7) begin
        checks++;
        if (busy2 !== 1'b0) begin
          errors++;
          $display("FAIL div1_busy_after_done: busy=%b, required 0", busy2);
        end
      end
      step();
      if (n == 0) start2 = 1'b0;
    end
    mon_sel = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL div1_pending: %0d events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] pats[2] = '{8'hA5, 8'h3C};
    logic [7:0] want;
    bit seen;
    for (int p = 0; p < 2; p++) begin
      step();
      tx = pats[p];
      rx_q.push_back(pats[p]);
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      seen = 1'b0;
      for (int w = 0; w < 100 && !seen; w++) begin
        @(negedge clk);
        if (done3) seen = 1'b1;
      end
      want = rx_q.pop_front();
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL loopback_timeout: no Done within 100 cycles, required Done");
      end else if (rx !== want) begin
        errors++;
        $display("FAIL loopback_data: got %h, required %h", rx, want);
      end
      step();
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; abort2 = 1'b0;
    start3 = 1'b0; abort3 = 1'b0; tx = 8'h00;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    test_div1();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
